// File: rtl/cf_pio_timing_ctrl.sv
// CompactFlash True-IDE PIO cycle sequencer behind an Avalon-MM slave.
// One Avalon transfer becomes one CF register/data cycle: address/CS setup,
// IORD_n/IOWR_n strobe (stretched by IORDY), a single hold cycle where the
// master is released, then CS-high recovery before the next cycle may start.
// Every output is a flop loaded from the next-state decode, so the CF pins
// and the Avalon handshake never carry combinational glitches.
module cf_pio_timing_ctrl #(
    parameter int T1_CYC      = 3,
    parameter int T2_CYC      = 8,
    parameter int T2I_CYC     = 6,
    parameter int RDY_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        av_chipselect,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [3:0]  av_address,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    input  logic        present,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic        busy,
    output logic [2:0]  cf_addr,
    output logic [1:0]  cf_cs_n,
    output logic        cf_iord_n,
    output logic        cf_iowr_n,
    output logic [15:0] cf_data_out,
    output logic        cf_data_oe,
    input  logic [15:0] cf_data_in,
    input  logic        cf_iordy
);

    // Terminal counts: each phase counter runs 0 .. N-1.
    localparam logic [15:0] T1_LAST  = 16'(T1_CYC - 1);
    localparam logic [15:0] T2_LAST  = 16'(T2_CYC - 1);
    localparam logic [15:0] T2I_LAST = 16'(T2I_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(RDY_TIMEOUT - 1);

    // Value returned to the master when no data could be fetched.
    localparam logic [15:0] ABORT_DATA = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_RDY,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    // Request latched at acceptance; the master's bus is not looked at again.
    logic        wr_q, wr_d;
    logic [3:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        abort_q, abort_d;     // skip RECOVER after HOLD
    logic        nocard_q, nocard_d;   // card absent: no CS/strobe at all

    // Read-capture and timeout events produced by the transition logic.
    logic        rd_cap;
    logic [15:0] rd_val;
    logic        to_set;
    logic        req;

    // IORDY synchroniser.
    logic        iordy_s1_q, iordy_s2_q;

    // Registered outputs and their next values.
    logic [15:0] readdata_q, readdata_d;
    logic        waitreq_q, waitreq_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [2:0]  cf_addr_q, cf_addr_d;
    logic [1:0]  cs_n_q, cs_n_d;
    logic        iord_n_q, iord_n_d;
    logic        iowr_n_q, iowr_n_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        active_d, strobe_d;

    // Phase counters stop at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign req = av_chipselect & (av_read | av_write);

    // Two-flop synchroniser for the asynchronous IORDY pin (idles high).
    always_ff @(posedge clk) begin
        if (reset) begin
            iordy_s1_q <= 1'b1;
            iordy_s2_q <= 1'b1;
        end else begin
            iordy_s1_q <= cf_iordy;
            iordy_s2_q <= iordy_s1_q;
        end
    end

    // FSM state, phase counter and latched request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            wr_q     <= 1'b0;
            addr_q   <= 4'd0;
            wdata_q  <= 16'd0;
            abort_q  <= 1'b0;
            nocard_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            abort_q  <= abort_d;
            nocard_q <= nocard_d;
        end
    end

    // Next-state, counter and capture decisions for the cycle sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        abort_d  = abort_q;
        nocard_d = nocard_q;
        rd_cap   = 1'b0;
        rd_val   = cf_data_in;
        to_set   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    // Read+write together is a write.
                    wr_d  = av_write;
                    cnt_d = 16'd0;
                    if (present) begin
                        addr_d   = av_address;
                        wdata_d  = av_writedata;
                        abort_d  = 1'b0;
                        nocard_d = 1'b0;
                        state_d  = S_SETUP;
                    end else begin
                        // No card: release the master at once with all-ones.
                        abort_d  = 1'b1;
                        nocard_d = 1'b1;
                        rd_cap   = ~av_write;
                        rd_val   = ABORT_DATA;
                        state_d  = S_HOLD;
                    end
                end
            end

            S_SETUP: begin
                if (cnt_q == T1_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            S_STROBE: begin
                if (cnt_q == T2_LAST) begin
                    cnt_d = 16'd0;
                    if (iordy_s2_q) begin
                        rd_cap  = ~wr_q;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT_RDY;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            S_WAIT_RDY: begin
                // A ready card on the last allowed cycle still completes normally.
                if (iordy_s2_q) begin
                    cnt_d   = 16'd0;
                    rd_cap  = ~wr_q;
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = 16'd0;
                    abort_d = 1'b1;
                    to_set  = 1'b1;
                    rd_cap  = ~wr_q;
                    rd_val  = ABORT_DATA;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            S_HOLD: begin
                cnt_d   = 16'd0;
                state_d = abort_q ? S_IDLE : S_RECOVER;
            end

            S_RECOVER: begin
                if (cnt_q == T2I_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end

            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin and handshake values for the state being entered.
    always_comb begin
        active_d   = (state_d == S_SETUP || state_d == S_STROBE ||
                      state_d == S_WAIT_RDY || state_d == S_HOLD) && !nocard_d;
        strobe_d   = (state_d == S_STROBE || state_d == S_WAIT_RDY);
        cs_n_d     = active_d ? (addr_d[3] ? 2'b01 : 2'b10) : 2'b11;
        iord_n_d   = !(strobe_d && !wr_d);
        iowr_n_d   = !(strobe_d && wr_d);
        oe_d       = active_d && wr_d;
        waitreq_d  = (state_d != S_HOLD);
        busy_d     = (state_d != S_IDLE);
        cf_addr_d  = addr_d[2:0];
        dout_d     = wdata_d;
        readdata_d = rd_cap ? rd_val : readdata_q;
        // A timeout landing together with a clear request keeps the flag set.
        err_d      = to_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= 16'd0;
            waitreq_q  <= 1'b1;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            cf_addr_q  <= 3'd0;
            cs_n_q     <= 2'b11;
            iord_n_q   <= 1'b1;
            iowr_n_q   <= 1'b1;
            dout_q     <= 16'd0;
            oe_q       <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            waitreq_q  <= waitreq_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cf_addr_q  <= cf_addr_d;
            cs_n_q     <= cs_n_d;
            iord_n_q   <= iord_n_d;
            iowr_n_q   <= iowr_n_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
        end
    end

    assign av_readdata    = readdata_q;
    assign av_waitrequest = waitreq_q;
    assign timeout_err    = err_q;
    assign busy           = busy_q;
    assign cf_addr        = cf_addr_q;
    assign cf_cs_n        = cs_n_q;
    assign cf_iord_n      = iord_n_q;
    assign cf_iowr_n      = iowr_n_q;
    assign cf_data_out    = dout_q;
    assign cf_data_oe     = oe_q;

endmodule

// File: tb/tb_cf_pio_timing_ctrl.sv
// Testbench for cf_pio_timing_ctrl: vector table, hand-written corner
// sequences and randomized transactions against a timing model.
module tb_cf_pio_timing_ctrl;

    localparam int T1  = 3;
    localparam int T2  = 8;
    localparam int T2I = 6;
    localparam int RT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        av_chipselect, av_read, av_write;
    logic [3:0]  av_address;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_waitrequest;
    logic        present, err_clr, timeout_err, busy;
    logic [2:0]  cf_addr;
    logic [1:0]  cf_cs_n;
    logic        cf_iord_n, cf_iowr_n;
    logic [15:0] cf_data_out;
    logic        cf_data_oe;
    logic [15:0] cf_data_in;
    logic        cf_iordy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] prev_rd;

    always #5 clk = ~clk;

    cf_pio_timing_ctrl #(
        .T1_CYC(T1), .T2_CYC(T2), .T2I_CYC(T2I), .RDY_TIMEOUT(RT)
    ) dut (
        .clk(clk), .reset(reset),
        .av_chipselect(av_chipselect), .av_read(av_read), .av_write(av_write),
        .av_address(av_address), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
        .present(present), .err_clr(err_clr), .timeout_err(timeout_err),
        .busy(busy), .cf_addr(cf_addr), .cf_cs_n(cf_cs_n),
        .cf_iord_n(cf_iord_n), .cf_iowr_n(cf_iowr_n),
        .cf_data_out(cf_data_out), .cf_data_oe(cf_data_oe),
        .cf_data_in(cf_data_in), .cf_iordy(cf_iordy)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic [15:0] din;
        bit          pres;
        int          lo_s;
        int          lo_len;
        int          hold;
        bit          to;
        logic [15:0] rd_exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raw IORDY level during period k: low inside [lo_s, lo_s+lo_len).
    function automatic bit raw_rdy(input int k, input int lo_s, input int lo_len);
        return !(k >= lo_s && k < lo_s + lo_len);
    endfunction

    // Timing model: the synchronised IORDY seen at edge e equals the raw level
    // during period e-2. The strobe ends at the first edge T1+T2+j (j=0..RT)
    // with the card ready; HOLD is the following period. None ready -> timeout.
    function automatic void ref_model(input bit wr, input bit pres,
                                      input int lo_s, input int lo_len,
                                      input logic [15:0] din, input logic [15:0] prev,
                                      output int hold, output bit to,
                                      output logic [15:0] rd);
        to   = 1'b0;
        hold = T1 + T2 + RT + 1;
        if (!pres) begin
            hold = 1;
            rd   = wr ? prev : 16'hFFFF;
            return;
        end
        for (int j = 0; j <= RT; j++) begin
            if (raw_rdy(T1 + T2 + j - 2, lo_s, lo_len)) begin
                hold = T1 + T2 + j + 1;
                rd   = wr ? prev : din;
                return;
            end
        end
        to = 1'b1;
        rd = wr ? prev : 16'hFFFF;
    endfunction

    function automatic logic [7:0] pack(input bit b, input bit w, input logic [1:0] cs,
                                        input bit ird, input bit iwr, input bit oe,
                                        input bit er);
        return {b, w, cs, ird, iwr, oe, er};
    endfunction

    // One transaction; caller is in an idle period. Periods are counted from
    // the edge that accepts the request (period 1 follows edge 0).
    task automatic run_txn(input string nm, input bit rd, input bit wr,
                           input logic [3:0] addr, input logic [15:0] wd,
                           input logic [15:0] din, input bit pres,
                           input int lo_s, input int lo_len,
                           input int hold, input bit to, input logic [15:0] rd_exp);
        int last;
        bit active, strobe;
        logic [1:0] cs_e;
        logic [7:0] act, exp;
        last = hold + ((!pres || to) ? 0 : T2I);
        av_chipselect = 1'b1;
        av_read       = rd;
        av_write      = wr;
        av_address    = addr;
        av_writedata  = wd;
        present       = pres;
        cf_data_in    = din;
        cf_iordy      = raw_rdy(0, lo_s, lo_len);
        tick();
        for (int k = 1; k <= last + 1; k++) begin
            active = pres && (k <= hold);
            strobe = pres && (k >= T1 + 1) && (k <= hold - 1);
            cs_e   = active ? (addr[3] ? 2'b01 : 2'b10) : 2'b11;
            exp = pack(k <= last, k != hold, cs_e, !(strobe && !wr), !(strobe && wr),
                       active && wr, to && (k >= hold));
            act = pack(busy, av_waitrequest, cf_cs_n, cf_iord_n, cf_iowr_n,
                       cf_data_oe, timeout_err);
            chk($sformatf("%s pins@%0d", nm, k), 32'(act), 32'(exp));
            if (k == hold) begin
                chk($sformatf("%s readdata", nm), 32'(av_readdata), 32'(rd_exp));
                if (pres) begin
                    chk($sformatf("%s cf_addr", nm), 32'(cf_addr), 32'(addr[2:0]));
                    if (wr)
                        chk($sformatf("%s data_out", nm), 32'(cf_data_out), 32'(wd));
                end
            end
            cf_iordy = raw_rdy(k, lo_s, lo_len);
            err_clr  = (k == hold - 1);
            if (k == hold + 1) begin
                av_chipselect = 1'b0;
                av_read       = 1'b0;
                av_write      = 1'b0;
            end else if (k > 1 && k < hold) begin
                av_address   = 4'($urandom);
                av_writedata = 16'($urandom);
            end
            tick();
        end
        cf_iordy = 1'b1;
        err_clr  = to;
        tick();
        err_clr = 1'b0;
        if (to)
            chk($sformatf("%s err_clr", nm), 32'(timeout_err), 32'd0);
        tick();
        tick();
        prev_rd = rd_exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // rd wr addr   wd        din       pres lo_s lo_len hold to rd_exp
        tbl[0]  = '{1'b1, 1'b0, 4'h7, 16'h0000, 16'h0050, 1'b1, 0,  0,   12, 1'b0, 16'h0050};
        tbl[1]  = '{1'b0, 1'b1, 4'h8, 16'hABCD, 16'h0000, 1'b1, 0,  0,   12, 1'b0, 16'h0050};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 16'h1234, 1'b1, 4,  20,  27, 1'b0, 16'h1234};
        tbl[3]  = '{1'b1, 1'b0, 4'h1, 16'h0000, 16'h5555, 1'b1, 4,  200, 28, 1'b1, 16'hFFFF};
        tbl[4]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 16'h00A5, 1'b1, 0,  0,   12, 1'b0, 16'h00A5};
        tbl[5]  = '{1'b1, 1'b0, 4'h7, 16'h0000, 16'h0050, 1'b0, 0,  0,   1,  1'b0, 16'hFFFF};
        tbl[6]  = '{1'b0, 1'b1, 4'h6, 16'h1111, 16'h0000, 1'b0, 0,  0,   1,  1'b0, 16'hFFFF};
        tbl[7]  = '{1'b0, 1'b1, 4'h9, 16'h5A5A, 16'h0000, 1'b1, 8,  3,   14, 1'b0, 16'hFFFF};
        tbl[8]  = '{1'b1, 1'b1, 4'h3, 16'h7E7E, 16'h4242, 1'b1, 0,  0,   12, 1'b0, 16'hFFFF};
        tbl[9]  = '{1'b1, 1'b0, 4'hC, 16'h0000, 16'h0F0F, 1'b1, 9,  1,   13, 1'b0, 16'h0F0F};
        tbl[10] = '{1'b1, 1'b0, 4'h4, 16'h0000, 16'h3C3C, 1'b1, 9,  16,  28, 1'b0, 16'h3C3C};
        tbl[11] = '{1'b1, 1'b0, 4'h5, 16'h0000, 16'h6666, 1'b1, 9,  17,  28, 1'b1, 16'hFFFF};

        reset = 1'b1;
        av_chipselect = 1'b0; av_read = 1'b0; av_write = 1'b0;
        av_address = 4'h0; av_writedata = 16'h0;
        present = 1'b1; err_clr = 1'b0; cf_data_in = 16'h0; cf_iordy = 1'b1;
        tick(); tick(); tick();

        // Reset state.
        chk("reset pins", 32'(pack(busy, av_waitrequest, cf_cs_n, cf_iord_n, cf_iowr_n,
                                   cf_data_oe, timeout_err)),
            32'(pack(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0)));
        chk("reset readdata", 32'(av_readdata), 32'd0);
        chk("reset cf_addr", 32'(cf_addr), 32'd0);
        chk("reset data_out", 32'(cf_data_out), 32'd0);
        reset = 1'b0;
        tick();
        prev_rd = 16'h0000;

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd,
                    tbl[i].din, tbl[i].pres, tbl[i].lo_s, tbl[i].lo_len,
                    tbl[i].hold, tbl[i].to, tbl[i].rd_exp);

        // Reset asserted while the read strobe is active.
        av_chipselect = 1'b1; av_read = 1'b1; av_write = 1'b0;
        av_address = 4'h5; cf_data_in = 16'h9999; present = 1'b1;
        tick();
        for (int k = 1; k < 6; k++) tick();
        chk("rst-mid strobe", 32'(cf_iord_n), 32'd0);
        reset = 1'b1;
        av_chipselect = 1'b0; av_read = 1'b0;
        tick();
        chk("rst-mid pins", 32'(pack(busy, av_waitrequest, cf_cs_n, cf_iord_n, cf_iowr_n,
                                     cf_data_oe, timeout_err)),
            32'(pack(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0)));
        chk("rst-mid readdata", 32'(av_readdata), 32'd0);
        reset = 1'b0;
        tick();
        prev_rd = 16'h0000;

        // Back-to-back writes with the request held: CS high through recovery.
        av_chipselect = 1'b1; av_write = 1'b1; av_read = 1'b0;
        av_address = 4'h0; av_writedata = 16'h1111;
        tick();
        for (int k = 1; k <= 32; k++) begin
            logic [1:0] cs_e;
            bit act_cs, stb;
            act_cs = (k <= 12) || (k >= 20 && k <= 31);
            stb    = (k >= 4 && k <= 11) || (k >= 23 && k <= 30);
            cs_e   = act_cs ? 2'b10 : 2'b11;
            chk($sformatf("b2b pins@%0d", k),
                32'(pack(busy, av_waitrequest, cf_cs_n, cf_iord_n, cf_iowr_n,
                         cf_data_oe, timeout_err)),
                32'(pack(k != 19, !(k == 12 || k == 31), cs_e, 1'b1, !stb, act_cs, 1'b0)));
            if (k == 12) chk("b2b data1", 32'(cf_data_out), 32'h1111);
            if (k == 31) chk("b2b data2", 32'(cf_data_out), 32'h2222);
            if (k == 13) av_writedata = 16'h2222;
            if (k == 31) begin
                av_chipselect = 1'b0;
                av_write      = 1'b0;
            end
            tick();
        end
        for (int k = 0; k < 8; k++) tick();
        chk("b2b idle", 32'(busy), 32'd0);

        // Randomized transactions against the timing model.
        for (int i = 0; i < 40; i++) begin
            bit rd, wr, pres, to;
            int mode, lo_s, lo_len, hold;
            logic [15:0] din, wd, rd_exp;
            logic [3:0] addr;
            mode   = $urandom_range(0, 2);
            rd     = (mode != 1);
            wr     = (mode != 0);
            pres   = ($urandom_range(0, 9) != 0);
            addr   = 4'($urandom);
            wd     = 16'($urandom);
            din    = 16'($urandom);
            lo_s   = $urandom_range(0, 14);
            lo_len = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(0, 6);
            ref_model(wr, pres, lo_s, lo_len, din, prev_rd, hold, to, rd_exp);
            run_txn($sformatf("rnd%0d", i), rd, wr, addr, wd, din, pres,
                    lo_s, lo_len, hold, to, rd_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
